// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: N-cycle unsigned shift-add or radix-2 Booth
// signed multiply with start/ready/done handshake and internally latched operands.
module seq_multiplier #(
  parameter int unsigned N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           ready,
  output logic           done
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N:0]    a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic          q1_q, q1_d;
  logic [N-1:0]  m_q, m_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] count_q, count_d;
  logic          busy_q, ready_q, done_q;

  logic [N:0]    m_ext;
  logic [N:0]    sum;
  logic [N:0]    step_a;
  logic [N-1:0]  step_q;

  // One multiply step: conditional add/subtract, then shift of {A,Q(,Q_1)}
  always_comb begin
    m_ext = mode_q ? {m_q[N-1], m_q} : {1'b0, m_q};
    sum   = a_q;
    if (!mode_q) begin
      if (q_q[0]) sum = a_q + m_ext;
    end else begin
      case ({q_q[0], q1_q})
        2'b01:   sum = a_q + m_ext;
        2'b10:   sum = a_q - m_ext;
        default: sum = a_q;
      endcase
    end
    step_a = {(mode_q ? sum[N] : 1'b0), sum[N:1]};
    step_q = {sum[0], q_q[N-1:1]};
  end

  // Next-state and datapath load/step control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    mode_d  = mode_q;
    count_d = count_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          mode_d  = signed_mode;
          a_d     = '0;
          q1_d    = 1'b0;
          count_d = LAST_COUNT;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = step_a;
        q_d     = step_q;
        q1_d    = q_q[0];
        count_d = count_q - CW'(1);
        if (count_q == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      mode_q  <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      busy_q  <= (state_d == S_RUN);
      ready_q <= (state_d == S_IDLE) || (state_d == S_DONE);
      // done marks only the entry into DONE, not the dwell
      done_q  <= (state_q == S_RUN) && (state_d == S_DONE);
    end
  end

  assign product = {a_q[N-1:0], q_q};
  assign busy    = busy_q;
  assign ready   = ready_q;
  assign done    = done_q;

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised sequential shift-add multiplier with its controller and datapath in one block. It multiplies two N-bit operands in N clock cycles, one multiplier bit per cycle, with a start/ready/done handshake. It extends the earlier fixed-width unsigned shift-add controller with a per-operation signed mode (radix-2 Booth). It also latches its own operands, so surrounding logic only presents operands and collects the product.

Parameters:
N, 4, operand width in bits; legal range 2..32; product width is 2N.

Ports:
clock  input  1  rising-edge clock for all state.
reset  input  1  synchronous, active-high; forces IDLE and clears all registers.
start  input  1  request; sampled on a clock edge only while ready=1.
signed_mode  input  1  0 = unsigned shift-add, 1 = two's-complement Booth; latched with the operands.
multiplicand  input  N  operand M; latched when start is accepted.
multiplier  input  N  operand Q; latched when start is accepted.
product  output  2N  result; valid while ready=1 after at least one completed operation.
busy  output  1  high in RUN.
ready  output  1  high in IDLE and DONE; start accepted only when high.
done  output  1  one-cycle pulse on the first cycle in DONE.

Behaviour:
- Reset (sync): state=IDLE, A=0, Q=0, Q_1=0, count=0, mode=0, product=0, busy=0, ready=1, done=0. Reset wins over start on the same edge.
- Registers:
  - A: N+1 bits, sign/carry guard bit included.
  - Q: N bits.
  - Q_1: 1 bit, Booth history.
  - M: N bits.
  - mode: 1 bit.
  - count: clog2(N) bits.
- States:
  - IDLE: ready=1. If start=1 at an edge: M<=multiplicand, Q<=multiplier, mode<=signed_mode, A<=0, Q_1<=0, count<=N-1, next state RUN.
  - RUN: busy=1, ready=0. One step per edge, count<=count-1. After the step taken with count==0, next state DONE. Exactly N steps are taken.
  - DONE: ready=1. done=1 only on the first cycle after entering. Holds the product indefinitely. start=1 accepted exactly as in IDLE, giving back-to-back operation.
  - Illegal encoding: next state IDLE.
- Step, unsigned (mode=0):
  - If Q[0]=1: A <= A + {1'b0,M}. The carry lands in A[N].
  - Then logical shift right of the {A,Q} concatenation by 1, with 0 entering A[N].
- Step, signed (mode=1), selected by {Q[0],Q_1}:
  - 01: A <= A + sext(M).
  - 10: A <= A - sext(M).
  - 00 or 11: A unchanged.
  - Then arithmetic shift right of {A,Q,Q_1} by 1. A[N] is replicated, and the old Q[0] moves into Q_1.
  - The N+1-bit A absorbs the M = -2^(N-1) case without overflow.
- product = {A[N-1:0], Q}, driven combinationally from the registers.
  - Not meaningful during RUN.
  - The bench checks it only when ready=1.
- Latency: if start is accepted at edge t, done=1 in the cycle after edge t+N, and product is final from that cycle onward.
- Boundary cases:
  - start during RUN: ignored; it is neither queued nor allowed to change the latched operands.
  - Input operand or signed_mode changes during RUN: no effect.
  - Zero operands: product=0.
  - All-ones unsigned: product=(2^N-1)^2 exactly, no truncation.
  - reset mid-RUN: IDLE on the next cycle, product=0, no done pulse.
  - start held high continuously: a new operation starts on every DONE cycle, so done pulses every N+1 cycles.

Test Plan:
- N=4, unsigned, 13*11, single start pulse -> done exactly 4 edges after acceptance; product=0x8F (143); busy high for exactly 4 cycles.
- N=4, unsigned, 15*15 -> product=0xE1; then 0*9 -> product=0x00.
- N=4, signed: 7*-3 -> 0xEB (-21); -8*-8 -> 0x40 (64); -8*7 -> 0xC8 (-56).
- N=4: start a 5*3 operation, then pulse start with operands 9*9 two cycles into RUN -> the second pulse is ignored; product=0x0F; single done pulse.
- N=4: start 6*6, assert reset in the 2nd RUN cycle -> next cycle state IDLE, ready=1, busy=0, product=0, no done pulse; a subsequent 2*3 gives 0x06.
- N=8, start held high, unsigned 200*100 then signed -128*-1 (operands switched on DONE) -> product=0x4E20, then 0x0080; done every 9 cycles.
